// File: rtl/score_bar_sequencer.sv
// score_bar_sequencer: paces one-block plot and bar-clear commands to the score-bar drawer
// using fixed wait counters, queueing correct words that arrive while a command is in flight.
module score_bar_sequencer #(
  parameter int MAX_BLOCKS   = 30,
  parameter int PLOT_CYCLES  = 64,
  parameter int CLEAR_CYCLES = 1600,
  parameter int PEND_DEPTH   = 7
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       word_correct,
  input  logic       game_reset,
  output logic       enable_plot_scorebar,
  output logic       enable_clear_scorebar,
  output logic [5:0] score,
  output logic [2:0] pending,
  output logic       busy,
  output logic       bar_full,
  output logic       overflow
);
  localparam int WW = $clog2(CLEAR_CYCLES + 1);
  localparam logic [5:0]    MAXB    = 6'(MAX_BLOCKS);
  localparam logic [2:0]    PDEP    = 3'(PEND_DEPTH);
  localparam logic [WW-1:0] PLOT_LD = WW'(PLOT_CYCLES - 1);
  localparam logic [WW-1:0] CLR_LD  = WW'(CLEAR_CYCLES - 1);
  localparam logic [WW-1:0] ONE     = WW'(1);
  typedef enum logic [2:0] {IDLE, PLOT_PULSE, PLOT_WAIT, CLEAR_PULSE, CLEAR_WAIT} state_t;
  state_t        state_q, state_d;
  logic [5:0]    score_q, score_d;
  logic [2:0]    pending_q, pending_d, pend_base;
  logic [WW-1:0] wait_q, wait_d;
  logic          clear_req_q, clear_req_d, overflow_q, overflow_d;
  logic          plot_q, plot_d, clr_q, clr_d, plot_done, discard;
  always_comb begin
    state_d     = state_q;
    score_d     = score_q;
    wait_d      = wait_q;
    clear_req_d = clear_req_q;
    overflow_d  = overflow_q;
    plot_done   = 1'b0;
    discard     = 1'b0;
    case (state_q)
      IDLE: begin
        if (clear_req_q) state_d = CLEAR_PULSE;
        else if (pending_q != 3'd0) begin
          if (score_q < MAXB) state_d = PLOT_PULSE;
          else discard = 1'b1;
        end
      end
      PLOT_PULSE: begin
        wait_d  = PLOT_LD;
        state_d = PLOT_WAIT;
      end
      PLOT_WAIT: begin
        wait_d = wait_q - ONE;
        if (wait_q <= ONE) begin
          plot_done = 1'b1;
          score_d   = score_q + 6'd1;
          state_d   = IDLE;
        end
      end
      CLEAR_PULSE: begin
        clear_req_d = 1'b0;
        score_d     = 6'd0;
        wait_d      = CLR_LD;
        state_d     = CLEAR_WAIT;
      end
      CLEAR_WAIT: begin
        if (wait_q == '0) begin
          state_d    = IDLE;
          overflow_d = 1'b0;
        end else wait_d = wait_q - ONE;
      end
      default: state_d = IDLE;
    endcase
    // A word landing on the plot-completion cycle nets to zero against the retire.
    pend_base = discard ? 3'd0 : (plot_done && pending_q != 3'd0) ? pending_q - 3'd1 : pending_q;
    pending_d = pend_base;
    if (game_reset) begin
      pending_d   = 3'd0;
      clear_req_d = 1'b1;
    end else if (word_correct) begin
      if (pend_base == PDEP) overflow_d = 1'b1;
      else pending_d = pend_base + 3'd1;
    end
    plot_d = state_d == PLOT_PULSE;
    clr_d  = state_d == CLEAR_PULSE;
  end
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= IDLE;
      score_q     <= '0;
      pending_q   <= '0;
      wait_q      <= '0;
      clear_req_q <= 1'b0;
      overflow_q  <= 1'b0;
      plot_q      <= 1'b0;
      clr_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      score_q     <= score_d;
      pending_q   <= pending_d;
      wait_q      <= wait_d;
      clear_req_q <= clear_req_d;
      overflow_q  <= overflow_d;
      plot_q      <= plot_d;
      clr_q       <= clr_d;
    end
  end
  assign enable_plot_scorebar  = plot_q;
  assign enable_clear_scorebar = clr_q;
  assign score    = score_q;
  assign pending  = pending_q;
  assign busy     = state_q != IDLE;
  assign bar_full = score_q == MAXB;
  assign overflow = overflow_q;
endmodule

// File: tb/tb_score_bar_sequencer.sv
// tb_score_bar_sequencer: directed vector table, timing sequences and random traffic
// checked every cycle against a command-age reference model of the sequencer.
module tb_score_bar_sequencer;
  localparam int PC = 64, CC = 1600, MB = 30, PD = 7;
  logic clk = 1'b0, resetn = 1'b1, word_correct = 1'b0, game_reset = 1'b0;
  logic enable_plot_scorebar, enable_clear_scorebar, busy, bar_full, overflow;
  logic [5:0] score;
  logic [2:0] pending;
  score_bar_sequencer dut (
    .clk(clk), .resetn(resetn), .word_correct(word_correct), .game_reset(game_reset),
    .enable_plot_scorebar(enable_plot_scorebar), .enable_clear_scorebar(enable_clear_scorebar),
    .score(score), .pending(pending), .busy(busy), .bar_full(bar_full), .overflow(overflow)
  );
  always #5 clk = ~clk;
  int checks = 0, errors = 0, cyc_n = 0;
  int plot_t[$], clr_t[$];
  // Model: kind 0 = idle, 1 = plot command, 2 = clear command; age 0 is the pulse cycle.
  int m_score, m_pend, m_kind, m_age;
  bit m_req, m_ovf;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d got %0d expected %0d", name, cyc_n, act, exp);
    end
  endtask
  task automatic model_reset();
    m_score = 0; m_pend = 0; m_kind = 0; m_age = 0; m_req = 0; m_ovf = 0;
  endtask
  task automatic model_step(input bit w, input bit g);
    int p, s, nk, na;
    bit done_p, done_c, pulse_c;
    p = m_pend; s = m_score; nk = m_kind; na = m_age + 1;
    done_p  = m_kind == 1 && m_age == PC - 1;
    done_c  = m_kind == 2 && m_age == CC;
    pulse_c = m_kind == 2 && m_age == 0;
    if (m_kind == 0) begin
      na = 0;
      if (m_req) nk = 2;
      else if (m_pend > 0 && m_score < MB) nk = 1;
    end else if (done_p || done_c) nk = 0;
    if (done_p) begin
      s++;
      if (p > 0) p--;
    end
    if (m_kind == 0 && !m_req && m_pend > 0 && m_score == MB) p = 0;
    if (pulse_c) begin
      s = 0;
      m_req = 0;
    end
    if (done_c) m_ovf = 0;
    if (g) begin
      p = 0;
      m_req = 1;
    end else if (w) begin
      if (p == PD) m_ovf = 1;
      else p++;
    end
    m_pend = p; m_score = s; m_kind = nk; m_age = na;
  endtask
  task automatic cmp_model();
    chk("enable_plot", 32'(enable_plot_scorebar), 32'(m_kind == 1 && m_age == 0));
    chk("enable_clear", 32'(enable_clear_scorebar), 32'(m_kind == 2 && m_age == 0));
    chk("score", 32'(score), 32'(m_score));
    chk("pending", 32'(pending), 32'(m_pend));
    chk("busy", 32'(busy), 32'(m_kind != 0));
    chk("bar_full", 32'(bar_full), 32'(m_score == MB));
    chk("overflow", 32'(overflow), 32'(m_ovf));
  endtask
  task automatic cyc(input bit w, input bit g);
    word_correct = w;
    game_reset = g;
    @(posedge clk);
    model_step(w, g);
    @(negedge clk);
    word_correct = 1'b0;
    game_reset = 1'b0;
    cyc_n++;
    cmp_model();
    if (enable_plot_scorebar) plot_t.push_back(cyc_n);
    if (enable_clear_scorebar) clr_t.push_back(cyc_n);
  endtask
  task automatic chk_zero(input string tag);
    chk({tag, " enable_plot"}, 32'(enable_plot_scorebar), 0);
    chk({tag, " enable_clear"}, 32'(enable_clear_scorebar), 0);
    chk({tag, " score"}, 32'(score), 0);
    chk({tag, " pending"}, 32'(pending), 0);
    chk({tag, " busy"}, 32'(busy), 0);
    chk({tag, " bar_full"}, 32'(bar_full), 0);
    chk({tag, " overflow"}, 32'(overflow), 0);
  endtask
  typedef struct {
    bit w; bit g; int wait_n; int score; int pend; bit busy; bit ovf; bit full;
  } vec_t;
  vec_t tbl[$];
  initial begin
    int k, n, s0, bc;
    tbl.push_back('{1, 0, 100, 1, 0, 0, 0, 0});
    tbl.push_back('{1, 0, 100, 2, 0, 0, 0, 0});
    tbl.push_back('{0, 1, 1700, 0, 0, 0, 0, 0});
    tbl.push_back('{1, 0, 0, 0, 1, 0, 0, 0});
    tbl.push_back('{1, 0, 0, 0, 2, 1, 0, 0});
    tbl.push_back('{1, 0, 300, 3, 0, 0, 0, 0});
    tbl.push_back('{0, 1, 1700, 0, 0, 0, 0, 0});
    for (int i = 1; i <= 8; i++) tbl.push_back('{1, 0, 0, 0, (i > 7) ? 7 : i, i >= 2, i == 8, 0});
    tbl.push_back('{0, 0, 500, 7, 0, 0, 1, 0});
    tbl.push_back('{0, 1, 10, 0, 0, 1, 1, 0});
    tbl.push_back('{0, 0, 1700, 0, 0, 0, 0, 0});
    #2 resetn = 1'b0;
    #1 chk_zero("reset");
    model_reset();
    @(negedge clk);
    @(negedge clk);
    resetn = 1'b1;
    foreach (tbl[i]) begin
      cyc(tbl[i].w, tbl[i].g);
      repeat (tbl[i].wait_n) cyc(0, 0);
      chk($sformatf("vec%0d score", i), 32'(score), 32'(tbl[i].score));
      chk($sformatf("vec%0d pending", i), 32'(pending), 32'(tbl[i].pend));
      chk($sformatf("vec%0d busy", i), 32'(busy), 32'(tbl[i].busy));
      chk($sformatf("vec%0d overflow", i), 32'(overflow), 32'(tbl[i].ovf));
      chk($sformatf("vec%0d bar_full", i), 32'(bar_full), 32'(tbl[i].full));
    end
    // single word: plot pulse two cycles after the word, score one 64 cycles after the pulse
    cyc(1, 0);
    k = 1;
    while (!enable_plot_scorebar && k < 10) begin cyc(0, 0); k++; end
    chk("plot_latency", k, 2);
    n = 0;
    while (score == 6'd0 && n < 200) begin cyc(0, 0); n++; end
    chk("score_latency", n, 64);
    chk("single pending", 32'(pending), 0);
    // three back-to-back words: three pulses 65 cycles apart
    s0 = int'(score);
    plot_t.delete();
    repeat (3) cyc(1, 0);
    repeat (300) cyc(0, 0);
    chk("burst plot count", plot_t.size(), 3);
    if (plot_t.size() == 3) begin
      chk("burst spacing1", plot_t[1] - plot_t[0], 65);
      chk("burst spacing2", plot_t[2] - plot_t[1], 65);
    end
    chk("burst score", 32'(score), 32'(s0 + 3));
    // fill the bar, then extra words are discarded
    k = 0;
    while (score != 6'(MB) && k < 40) begin cyc(1, 0); repeat (70) cyc(0, 0); k++; end
    chk("fill score", 32'(score), MB);
    chk("fill bar_full", 32'(bar_full), 1);
    plot_t.delete();
    cyc(1, 0);
    cyc(1, 0);
    repeat (20) cyc(0, 0);
    chk("full plot count", plot_t.size(), 0);
    chk("full pending", 32'(pending), 0);
    chk("full bar_full", 32'(bar_full), 1);
    // game_reset inside a plot wait with two words queued
    cyc(0, 1);
    repeat (1700) cyc(0, 0);
    cyc(1, 0);
    cyc(1, 0);
    repeat (10) cyc(0, 0);
    chk("midwait pending", 32'(pending), 2);
    chk("midwait busy", 32'(busy), 1);
    plot_t.delete();
    clr_t.delete();
    cyc(0, 1);
    k = 0;
    while (!enable_clear_scorebar && k < 200) begin cyc(0, 0); k++; end
    chk("midwait score_at_clear", 32'(score), 1);
    bc = 0;
    while (busy && bc < 3000) begin bc++; cyc(0, 0); end
    chk("midwait busy_len", bc, 1601);
    chk("midwait clear count", clr_t.size(), 1);
    chk("midwait plot count", plot_t.size(), 0);
    chk("midwait score", 32'(score), 0);
    chk("midwait pending_end", 32'(pending), 0);
    // word and reset together, then async reset mid clear wait
    plot_t.delete();
    clr_t.delete();
    cyc(1, 1);
    chk("coincide pending", 32'(pending), 0);
    repeat (100) cyc(0, 0);
    chk("coincide clear count", clr_t.size(), 1);
    chk("coincide plot count", plot_t.size(), 0);
    #2 resetn = 1'b0;
    #1 chk_zero("async");
    model_reset();
    @(negedge clk);
    chk_zero("async held");
    resetn = 1'b1;
    for (int i = 0; i < 6000; i++) cyc($urandom_range(0, 9) == 0, $urandom_range(0, 1499) == 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
